seq_detect_ctrl: RTL and testbench

//  Word-level controller for serial pattern detection: accepts DW-bit words over

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/seq_detect_core.sv | 55 +++++
 rtl/seq_detect_ctrl.sv | 125 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - FSM encodings, default pattern and counter sizing for seq_detect_ctrl
package seq_detect_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] PAT_DEF_C = 4'b1011;

  // Width needed to hold a down-counter running from n-1 to 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_detect_core.sv
// rtl/seq_detect_core.sv - programmable Moore detector: bit history, fill level, pattern register
// match_nxt exposes the value o_match takes on the coming bit edge so the controller can count in step.
module seq_detect_core
  import seq_detect_pkg::*;
#(
  parameter int              PW      = 4,
  parameter logic [PW-1:0]   PAT_DEF = PAT_DEF_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_in,
  input  logic          bit_valid,
  input  logic          clear,
  input  logic          load,
  input  logic [PW-1:0] pat_in,
  output logic          match,
  output logic          match_nxt
);

  localparam int FW = $clog2(PW + 1);

  logic [PW-1:0] pattern;
  logic [PW-1:0] hist;
  logic [PW-1:0] hist_nxt;
  logic [FW-1:0] fill;

  assign hist_nxt  = {hist[PW-2:0], bit_in};
  // A match needs PW real bits of history, counting the one arriving now.
  assign match_nxt = (hist_nxt == pattern) && (fill >= FW'(PW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= PAT_DEF;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else begin
      if (load) begin
        pattern <= pat_in;
      end
      if (clear) begin
        hist  <= '0;
        fill  <= '0;
        match <= 1'b0;
      end else if (bit_valid) begin
        hist  <= hist_nxt;
        match <= match_nxt;
        if (fill != FW'(PW)) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - word-level controller feeding words MSB-first into seq_detect_core
// Build option SEQ_DETECT_CTRL_SAT_EN: o_cnt saturates instead of wrapping.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int            DW      = 8,
  parameter int            PW      = 4,
  parameter int            CW      = 8,
  parameter logic [PW-1:0] PAT_DEF = PAT_DEF_C
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [PW-1:0] i_pat,
  input  logic          i_pat_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_match,
  output logic          o_done,
  output logic          o_hit,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy
);

  localparam int BW = cnt_width(DW);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] sreg;
  logic [BW-1:0] bcnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          word_hit;
  logic          hit;
  logic          done;
  logic          accept;
  logic          pat_load;
  logic          shift_en;
  logic          match_nxt;

  assign accept   = (state == S_IDLE) && i_valid;
  assign pat_load = (state == S_IDLE) && i_pat_load;
  assign shift_en = (state == S_SHIFT);

`ifdef SEQ_DETECT_CTRL_SAT_EN
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
`else
  assign cnt_inc = cnt + 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (bcnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == S_IDLE) && !i_rst;
    o_busy  = (state == S_SHIFT) || (state == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sreg     <= '0;
      bcnt     <= '0;
      cnt      <= '0;
      word_hit <= 1'b0;
      hit      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (accept) begin
        sreg     <= i_data;
        bcnt     <= BW'(DW - 1);
        word_hit <= 1'b0;
      end else if (shift_en) begin
        sreg <= {sreg[DW-2:0], 1'b0};
        bcnt <= bcnt - 1'b1;
        if (match_nxt) begin
          word_hit <= 1'b1;
        end
      end
      if (pat_load) begin
        cnt <= '0;
      end else if (shift_en && match_nxt) begin
        cnt <= cnt_inc;
      end
      if (state == S_DONE) begin
        hit <= word_hit;
      end
    end
  end

  seq_detect_core #(
    .PW      (PW),
    .PAT_DEF (PAT_DEF)
  ) u_core (
    .clk       (i_clk),
    .rst       (i_rst),
    .bit_in    (sreg[DW-1]),
    .bit_valid (shift_en),
    .clear     (pat_load),
    .load      (pat_load),
    .pat_in    (i_pat),
    .match     (o_match),
    .match_nxt (match_nxt)
  );

  assign o_done = done;
  assign o_hit  = hit;
  assign o_cnt  = cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - self-checking bench for seq_detect_ctrl against a bit-stream model
module tb_seq_detect_ctrl;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [PW-1:0] i_pat;
  logic          i_pat_load;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_match;
  logic          o_done;
  logic          o_hit;
  logic [CW-1:0] o_cnt;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  seq_detect_ctrl #(.DW(DW), .PW(PW), .CW(CW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pat      (i_pat),
    .i_pat_load (i_pat_load),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_match    (o_match),
    .o_done     (o_done),
    .o_hit      (o_hit),
    .o_cnt      (o_cnt),
    .o_busy     (o_busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every bit since reset/load kept in order; a match is the
  // newest PW bits spelling the pattern (newest bit = pattern LSB).
  bit            stream_q[$];
  logic [PW-1:0] m_pat;
  int            m_total;

  function automatic bit m_push(input bit b);
    stream_q.push_back(b);
    if (stream_q.size() < PW) return 1'b0;
    for (int k = 0; k < PW; k++) begin
      if (stream_q[stream_q.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef SEQ_DETECT_CTRL_SAT_EN
    return (m_total > 255) ? 32'd255 : 32'(m_total);
`else
    return 32'(m_total % 256);
`endif
  endfunction

  task automatic m_reset();
    stream_q.delete();
    m_pat   = 4'b1011;
    m_total = 0;
  endtask

  task automatic send_word(input logic [DW-1:0] data, input bit load,
                           input logic [PW-1:0] pat, input bit mid_load);
    int tries = 0;
    bit any   = 1'b0;
    bit early = 1'b0;
    bit m;
    while (!o_ready && tries < 40) begin
      @(negedge i_clk);
      tries++;
    end
    check("ready_wait", o_ready, 1);
    i_valid    = 1'b1;
    i_data     = data;
    i_pat_load = load;
    i_pat      = pat;
    if (load) begin
      m_pat = pat;
      stream_q.delete();
      m_total = 0;
    end
    @(posedge i_clk);
    #1;
    i_valid    = 1'b0;
    i_pat_load = 1'b0;
    i_data     = DW'($urandom);
    for (int c = 0; c <= DW + 1; c++) begin
      @(negedge i_clk);
      if (mid_load && c == 3) begin
        i_pat_load = 1'b1;
        i_pat      = ~m_pat;
      end else begin
        i_pat_load = 1'b0;
      end
      if (c == 1) check("busy", o_busy, 1);
      if (c >= 1 && c <= DW) begin
        m = m_push(data[DW-c]);
        if (m) begin
          m_total++;
          any = 1'b1;
        end
        check($sformatf("match_bit%0d", c), o_match, m);
      end
      if (c <= DW && o_done) early = 1'b1;
    end
    check("early_done", early, 0);
    check("done_lat", o_done, 1);
    check("hit", o_hit, any);
    check("cnt", o_cnt, exp_cnt());
  endtask

  initial begin
    i_rst      = 1'b1;
    i_pat      = '0;
    i_pat_load = 1'b0;
    i_data     = '0;
    i_valid    = 1'b0;
    m_reset();

    repeat (4) @(negedge i_clk);
    check("rst_ready", o_ready, 0);
    check("rst_match", o_match, 0);
    check("rst_done",  o_done, 0);
    check("rst_hit",   o_hit, 0);
    check("rst_cnt",   o_cnt, 0);
    check("rst_busy",  o_busy, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rel_ready", o_ready, 1);

    send_word(8'b1011_0110, 1'b0, '0, 1'b0);
    check("t2_cnt", o_cnt, 2);

    send_word(8'b0000_0010, 1'b1, 4'b1011, 1'b0);
    check("t3_hit1", o_hit, 0);
    send_word(8'b1100_0000, 1'b0, '0, 1'b0);
    check("t3_hit2", o_hit, 1);
    check("t3_cnt", o_cnt, 1);

    send_word(8'hA5, 1'b0, '0, 1'b1);
    send_word(8'hFF, 1'b1, 4'b1111, 1'b0);
    check("t4_cnt", o_cnt, 5);

    send_word(8'h00, 1'b1, 4'b0000, 1'b0);
    for (int w = 1; w < 40; w++) send_word(8'h00, 1'b0, '0, 1'b0);
`ifdef SEQ_DETECT_CTRL_SAT_EN
    check("t5_cnt", o_cnt, 255);
`else
    check("t5_cnt", o_cnt, 61);
`endif

    send_word(8'h0F, 1'b1, 4'b1111, 1'b0);
    i_valid = 1'b1;
    i_data  = 8'hFF;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      check("t6_done", o_done, 0);
      check("t6_ready", o_ready, 0);
      check("t6_cnt", o_cnt, 0);
    end
    i_rst = 1'b0;
    m_reset();
    @(negedge i_clk);
    check("t6_rel_ready", o_ready, 1);
    check("t6_rel_done", o_done, 0);
    send_word(8'b1011_0110, 1'b0, '0, 1'b0);
    check("t6_cnt2", o_cnt, 2);

    for (int w = 0; w < 30; w++) begin
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(2)) @(negedge i_clk);
      end
      send_word(DW'($urandom), ($urandom_range(4) == 0), PW'($urandom), ($urandom_range(5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
